// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU, 8 ops, registered result/flags, optional iterative unsigned MOD (`ALU_MC_MOD_EN`).
// Latency start->done: 2 cycles; MOD with b!=0 takes WIDTH+2 cycles (only when ALU_MC_MOD_EN is defined).
// Backpressure: ready=1 only in IDLE; start while busy is dropped, not queued.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

`ifdef ALU_MC_MOD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MOD_RUN = 2'd2, DONE = 2'd3} state_t;
  localparam int CW = $clog2(WIDTH + 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state, state_nxt;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] op_a, op_b;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   sum_ext;
  logic             alu_c, alu_v, alu_dz;

`ifdef ALU_MC_MOD_EN
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   trial, diff;
  logic [WIDTH-1:0] rem_nxt;

  // Partial remainder is WIDTH+1 wide during the trial subtraction; the kept remainder fits WIDTH.
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    diff    = trial - {1'b0, op_b};
    rem_nxt = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  end
`endif

  always_comb begin
    alu_res = '0;
    sum_ext = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_dz  = 1'b0;
    case (op_sel)
      3'd0: alu_res = op_a & op_b;
      3'd1: alu_res = op_a | op_b;
      3'd2: alu_res = op_a ^ op_b;
      3'd3: alu_res = ~(op_a | op_b);
      3'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'd5: begin
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      3'd6: begin
        sum_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
      default: begin
`ifdef ALU_MC_MOD_EN
        // Only the divide-by-zero MOD reaches EXEC; the iterative path writes its own result.
        alu_res = op_a;
`else
        alu_res = '0;
`endif
        alu_dz  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef ALU_MC_MOD_EN
          if (sel == 3'd7 && b != '0) state_nxt = MOD_RUN;
          else                        state_nxt = EXEC;
`else
          state_nxt = EXEC;
`endif
        end
      end
      EXEC:    state_nxt = DONE;
`ifdef ALU_MC_MOD_EN
      MOD_RUN: if (cnt == CW'(WIDTH)) state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_sel   <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      div_zero <= 1'b0;
`ifdef ALU_MC_MOD_EN
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_sel <= sel;
        op_a   <= a;
        op_b   <= b;
`ifdef ALU_MC_MOD_EN
        rem    <= '0;
        quo    <= a;
        cnt    <= '0;
`endif
      end
      if (state == EXEC) begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        carry    <= alu_c;
        overflow <= alu_v;
        div_zero <= alu_dz;
      end
`ifdef ALU_MC_MOD_EN
      // WIDTH shift/subtract steps, then one cycle to publish the remainder.
      if (state == MOD_RUN) begin
        if (cnt != CW'(WIDTH)) begin
          rem <= rem_nxt;
          quo <= {quo[WIDTH-2:0], 1'b0};
          cnt <= cnt + CW'(1);
        end else begin
          result   <= rem;
          zero     <= (rem == '0);
          carry    <= 1'b0;
          overflow <= 1'b0;
          div_zero <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
